// File: rtl/serial_operand_feeder.sv
// Feeds two WIDTH-bit operands LSB-first into a bit-serial adder, with a one-cycle
// carry-clear before each frame and framing flags for the downstream collector.
module serial_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             adder_rst,
  output logic             bit_valid,
  output logic [IW-1:0]    bit_index,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [IW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          sh_a <= op_a;
          sh_b <= op_b;
          cnt  <= '0;
        end
        SHIFT: begin
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          // counter parks on the last index so it never wraps inside a frame
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    bit_valid = 1'b0;
    bit_index = '0;
    last_bit  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = SHIFT;
      SHIFT: begin
        a         = sh_a[0];
        b         = sh_b[0];
        bit_valid = 1'b1;
        bit_index = cnt;
        last_bit  = (cnt == LAST);
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // the adder's carry is held clear during our own reset as well as each frame start
  assign adder_rst = rst || (state == CLEAR);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench: WIDTH=8 and WIDTH=5 feeders, each driving a reference serial adder.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, a, b, adder_rst, bit_valid, last_bit, busy, done;
  logic [7:0] op_a, op_b;
  logic [2:0] bit_index;

  logic       in_valid5, in_ready5, a5, b5, adder_rst5, bit_valid5, last_bit5, busy5, done5;
  logic [4:0] op_a5, op_b5;
  logic [2:0] bit_index5;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int hs_q[$];
  logic carry8, carry5;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .a(a), .b(b), .adder_rst(adder_rst),
    .bit_valid(bit_valid), .bit_index(bit_index), .last_bit(last_bit),
    .busy(busy), .done(done)
  );

  serial_operand_feeder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .op_a(op_a5), .op_b(op_b5), .a(a5), .b(b5), .adder_rst(adder_rst5),
    .bit_valid(bit_valid5), .bit_index(bit_index5), .last_bit(last_bit5),
    .busy(busy5), .done(done5)
  );

  // reference LSB-first serial adders; stream bit = a ^ b ^ carry
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && !rst) hs_q.push_back(cyc);
    carry8 <= adder_rst  ? 1'b0 : ((a & b) | (a & carry8) | (b & carry8));
    carry5 <= adder_rst5 ? 1'b0 : ((a5 & b5) | (a5 & carry5) | (b5 & carry5));
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle.
  task automatic frame8(input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] es,
                        input bit hold, input bit inject);
    logic [7:0] ga, gb, gs;
    op_a = oa; op_b = ob; in_valid = 1'b1;
    chk("idle_in_ready", in_ready, 1);
    @(negedge clk);
    chk("clear_adder_rst", adder_rst, 1);
    chk("clear_bit_valid", bit_valid, 0);
    chk("clear_busy", busy, 1);
    chk("clear_ab", {a, b}, 0);
    if (!hold) in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inject && i == 2) begin
        in_valid = 1'b1; op_a = ~oa; op_b = ~ob;
        chk("busy_in_ready", in_ready, 0);
      end
      if (inject && i == 4) in_valid = 1'b0;
      chk("shift_bit_valid", bit_valid, 1);
      chk("shift_bit_index", bit_index, i);
      chk("shift_last_bit", last_bit, (i == 7));
      chk("shift_adder_rst", adder_rst, 0);
      ga[i] = a; gb[i] = b; gs[i] = a ^ b ^ carry8;
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_bit_valid", bit_valid, 0);
    chk("done_last_bit", last_bit, 0);
    @(negedge clk);
    chk("post_done_low", done, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("a_sequence", ga, oa);
    chk("b_sequence", gb, ob);
    chk("sum", gs, es);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h96};
    vecs[1] = '{8'h12, 8'h34, 8'h46};
    vecs[2] = '{8'h7F, 8'h01, 8'h80};
    vecs[3] = '{8'hA5, 8'h5A, 8'hFF};
    vecs[4] = '{8'h80, 8'h80, 8'h00};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE};

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    in_valid5 = 1'b0; op_a5 = '0; op_b5 = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_ab", {a, b}, 0);
    chk("rst_bit_index", bit_index, 0);
    chk("rst_adder_rst", adder_rst, 1);
    rst = 1'b0;
    #1 chk("post_rst_adder_rst", adder_rst, 0);
    @(negedge clk);

    for (int v = 0; v < 6; v++) frame8(vecs[v].a, vecs[v].b, vecs[v].sum, 1'b0, 1'b0);

    // back-to-back with in_valid held: carry of FF+01 must not leak into 00+00
    hs_q.delete();
    frame8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    frame8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("b2b_handshakes", hs_q.size(), 2);
    if (hs_q.size() == 2) chk("b2b_spacing", hs_q[1] - hs_q[0], 11);

    // new operands offered mid-frame are ignored
    frame8(8'hC3, 8'h0F, 8'hD2, 1'b0, 1'b1);
    @(negedge clk);
    chk("inject_no_reload", busy, 0);

    // reset at bit_index 3 aborts the frame
    op_a = 8'hF0; op_b = 8'h0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("abort_at_index", bit_index, 3);
    rst = 1'b1;
    #1 chk("abort_adder_rst", adder_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    frame8(8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    // reset beats a simultaneous in_valid
    rst = 1'b1; in_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_wins_busy", busy, 0);
    @(negedge clk);
    chk("rst_wins_no_clear", adder_rst, 0);

    // WIDTH=5: 1F+01 overflows to 5'h00; done seven cycles after the handshake
    begin
      logic [4:0] gs5;
      int nbits = 0, done_at = -1;
      gs5 = '0;
      op_a5 = 5'h1F; op_b5 = 5'h01; in_valid5 = 1'b1;
      chk("w5_in_ready", in_ready5, 1);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) begin
          in_valid5 = 1'b0;
          chk("w5_clear", adder_rst5, 1);
        end
        if (bit_valid5) begin
          chk("w5_bit_index", bit_index5, nbits);
          chk("w5_last_bit", last_bit5, (nbits == 4));
          if (nbits < 5) gs5[nbits] = a5 ^ b5 ^ carry5;
          nbits++;
        end
        if (done5) begin
          done_at = k;
          break;
        end
      end
      chk("w5_bit_count", nbits, 5);
      chk("w5_done_cycle", done_at, 7);
      chk("w5_sum", gs5, 5'h00);
      @(negedge clk);
      chk("w5_idle", in_ready5, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
